// File: rtl/fifo_uart_tx.sv
// Serial transmitter that drains an upstream FIFO: pops one word per frame and
// shifts it out as start bit, data LSB first, optional parity bit, stop bit.
module fifo_uart_tx #(
  parameter int bits       = 8,
  parameter int clk_div    = 4,
  parameter int parity_en  = 0,
  parameter int parity_odd = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            pndng,
  input  logic [bits-1:0] Din,
  output logic            pop,
  output logic            tx,
  output logic            busy,
  output logic            frame_done
);

  localparam int DIV_W = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam int BIT_W = $clog2(bits) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(clk_div - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(bits - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [bits-1:0]   shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              bit_end;

  assign bit_end = (div_cnt_q == DIV_LAST);

  // Reset is folded in so the FIFO never advances while the transmitter is held.
  assign pop        = ~rst & en & pndng &
                      ((state_q == IDLE) | ((state_q == STOP) & bit_end));
  assign busy       = (state_q != IDLE);
  assign tx         = tx_q;
  assign frame_done = done_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it unassigned and infer a latch.
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    done_d    = 1'b0;
    tx_d      = 1'b1;

    if (state_q != IDLE) div_cnt_d = bit_end ? '0 : div_cnt_q + 1'b1;

    case (state_q)
      IDLE: ;
      START: if (bit_end) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (bit_end) begin
        shreg_d = shreg_q >> 1;
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          state_d   = (parity_en != 0) ? PARITY : STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A pop overrides the STOP->IDLE exit, giving back-to-back frames.
    if (pop) begin
      shreg_d   = Din;
      par_d     = (parity_odd != 0) ? ~^Din : ^Din;
      div_cnt_d = '0;
      state_d   = START;
    end

    // tx is registered from the next state so the line changes with the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: four instances cover defaults, even and odd
// parity, and a one-cycle bit time; expected frames are hand-written bit vectors.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en_v, pndng_v, pop_v, tx_v, busy_v, done_v;
  logic [7:0] din_v [4];
  logic [7:0] words [2];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         idx;

  always #5 clk = ~clk;

  fifo_uart_tx #(.bits(8), .clk_div(4), .parity_en(0), .parity_odd(0)) u_dflt (
    .clk(clk), .rst(rst), .en(en_v[0]), .pndng(pndng_v[0]), .Din(din_v[0]),
    .pop(pop_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(done_v[0]));

  fifo_uart_tx #(.bits(8), .clk_div(4), .parity_en(1), .parity_odd(0)) u_even (
    .clk(clk), .rst(rst), .en(en_v[1]), .pndng(pndng_v[1]), .Din(din_v[1]),
    .pop(pop_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(done_v[1]));

  fifo_uart_tx #(.bits(8), .clk_div(4), .parity_en(1), .parity_odd(1)) u_odd (
    .clk(clk), .rst(rst), .en(en_v[2]), .pndng(pndng_v[2]), .Din(din_v[2]),
    .pop(pop_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(done_v[2]));

  fifo_uart_tx #(.bits(8), .clk_div(1), .parity_en(0), .parity_odd(0)) u_div1 (
    .clk(clk), .rst(rst), .en(en_v[3]), .pndng(pndng_v[3]), .Din(din_v[3]),
    .pop(pop_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .frame_done(done_v[3]));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One frame on instance u; exp holds the frame bits with the start bit at index 0.
  task automatic send_frame(input int u, input logic [7:0] d, input int div,
                            input int nbit, input logic [15:0] exp, input string tag);
    int pops  = 0;
    int dones = 0;
    int len   = nbit * div;
    @(negedge clk);
    din_v[u] = d; pndng_v[u] = 1'b1; en_v[u] = 1'b1;
    #1 check({tag, "_pop0"}, pop_v[u], 1);
    @(posedge clk);
    #1 pndng_v[u] = 1'b0;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      pops  += int'(pop_v[u]);
      dones += int'(done_v[u]);
      if (k <= len) check($sformatf("%s_tx%0d", tag, k), tx_v[u], exp[(k-1)/div]);
      if (k == len) begin
        check({tag, "_busy_last"}, busy_v[u], 1);
        check({tag, "_done_early"}, done_v[u], 0);
      end
      if (k == len + 1) begin
        check({tag, "_done"}, done_v[u], 1);
        check({tag, "_busy_after"}, busy_v[u], 0);
        check({tag, "_tx_idle"}, tx_v[u], 1);
      end
    end
    check({tag, "_extra_pops"}, pops, 0);
    check({tag, "_done_count"}, dones, 1);
    en_v[u] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad, pops, dones, popc, p;
    int pop_cyc [4];
    rst = 1'b1; en_v = '0; pndng_v = '0;
    for (int i = 0; i < 4; i++) din_v[i] = 8'h00;
    words[0] = 8'h01; words[1] = 8'hFF;

    // Reset state, including pop gated while reset is high.
    #3;
    check("rst_tx", tx_v, 4'hF);
    check("rst_busy", busy_v, 4'h0);
    check("rst_done", done_v, 4'h0);
    en_v[0] = 1'b1; pndng_v[0] = 1'b1;
    #1 check("rst_pop", pop_v[0], 0);
    en_v[0] = 1'b0; pndng_v[0] = 1'b0;
    @(negedge clk); rst = 1'b0;

    // Single frames: A5 default, 07 even/odd parity, 3C with one-cycle bits.
    send_frame(0, 8'hA5, 4, 10, 16'b1101001010,  "t1");
    send_frame(1, 8'h07, 4, 11, 16'b11000001110, "t3e");
    send_frame(2, 8'h07, 4, 11, 16'b10000001110, "t3o");
    send_frame(3, 8'h3C, 1, 10, 16'b1001111000,  "t6");

    // Back-to-back: FIFO model holds 01 then FF.
    idx = 0; popc = 0; dones = 0;
    for (int i = 0; i < 4; i++) pop_cyc[i] = -1;
    @(negedge clk);
    en_v[0] = 1'b1; pndng_v[0] = 1'b1; din_v[0] = words[0];
    for (int c = 0; c <= 90; c++) begin
      #1;
      p = int'(pop_v[0]);
      if (p != 0) begin
        if (popc < 4) pop_cyc[popc] = c;
        popc++;
      end
      dones += int'(done_v[0]);
      if (c == 41 || c == 81) check($sformatf("t2_done%0d", c), done_v[0], 1);
      if (c == 1 || c == 9 || c == 41 || c == 44) check($sformatf("t2_tx%0d", c), tx_v[0], 0);
      if (c == 5 || c == 40 || c == 45 || c == 80) check($sformatf("t2_tx%0d", c), tx_v[0], 1);
      if (c == 85) begin
        check("t2_busy_end", busy_v[0], 0);
        check("t2_tx_end", tx_v[0], 1);
      end
      @(posedge clk);
      #1;
      if (p != 0) begin
        idx++;
        pndng_v[0] = (idx < 2);
        if (idx < 2) din_v[0] = words[idx];
      end
      @(negedge clk);
    end
    check("t2_pop_count", popc, 2);
    check("t2_pop0_cycle", pop_cyc[0], 0);
    check("t2_pop1_cycle", pop_cyc[1], 40);
    check("t2_done_count", dones, 2);
    en_v[0] = 1'b0;

    // Asynchronous reset in the middle of data bit 3.
    @(negedge clk);
    din_v[0] = 8'hA5; pndng_v[0] = 1'b1; en_v[0] = 1'b1;
    @(posedge clk);
    #1 pndng_v[0] = 1'b0;
    repeat (18) @(negedge clk);
    check("t4_tx_bit3", tx_v[0], 0);
    check("t4_busy_pre", busy_v[0], 1);
    pndng_v[0] = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("t4_tx_rst", tx_v[0], 1);
    check("t4_busy_rst", busy_v[0], 0);
    check("t4_pop_rst", pop_v[0], 0);
    @(negedge clk);
    pndng_v[0] = 1'b0;
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (pop_v[0] || !tx_v[0] || busy_v[0]) bad++;
    end
    check("t4_idle_after", bad, 0);
    en_v[0] = 1'b0;

    // Gating: no data, then data but disabled.
    @(negedge clk);
    en_v[0] = 1'b1; pndng_v[0] = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (pop_v[0] || !tx_v[0]) bad++;
    end
    check("t5_no_pndng", bad, 0);
    en_v[0] = 1'b0; pndng_v[0] = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (pop_v[0] || !tx_v[0]) bad++;
    end
    check("t5_no_en", bad, 0);

    // Dropping en mid-frame: the frame finishes, nothing more is popped.
    din_v[0] = 8'h5A; en_v[0] = 1'b1;
    #1 check("t5_pop0", pop_v[0], 1);
    @(posedge clk);
    #1 en_v[0] = 1'b0;
    pops = 0; dones = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      pops  += int'(pop_v[0]);
      dones += int'(done_v[0]);
      if (k == 1)  check("t5_start", tx_v[0], 0);
      if (k == 40) check("t5_stop", tx_v[0], 1);
      if (k == 41) check("t5_done", done_v[0], 1);
    end
    check("t5_extra_pops", pops, 0);
    check("t5_done_count", dones, 1);
    check("t5_busy_end", busy_v[0], 0);
    pndng_v[0] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
